// File: rtl/axi4_video_stream_checker_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axi4_video_pkg
//  Description : Shared definitions for the colour-bar video stream checker.
//                Holds the 8 colour-bar pixel values (shared with the
//                pattern generator), the checker FSM state encoding and the
//                bar_idx() helper that maps a pixel column to its bar.
//  Revision    : 1.0  initial release
// ============================================================================
package axi4_video_pkg;

    // Checker FSM states
    typedef enum logic [1:0] {
        WAIT_SOF   = 2'd0,
        ACTIVE     = 2'd1,
        EXPECT_SOF = 2'd2
    } state_t;

    // Colour-bar pixel values, bar 0 (left) to bar 7 (right).
    // Three 10-bit components packed into bits [29:0].
    localparam logic [31:0] BAR_COLOURS [8] = '{
        32'h0000_0000,
        32'h0000_03FF,
        32'h000F_FC00,
        32'h000F_FFFF,
        32'h3FF0_0000,
        32'h3FF0_03FF,
        32'h3FFF_FC00,
        32'h3FFF_FFFF
    };

    // Bar index of column x: the number of bar borders k*W (k=1..7) that
    // lie at or before x. x_active is an elaboration-time constant, so the
    // division folds away and only a chain of comparators remains.
    // Columns past 8*W stay in bar 7.
    function automatic logic [2:0] bar_idx(input int unsigned x,
                                           input int unsigned x_active);
        int unsigned w;
        logic [2:0]  idx;
        w   = x_active / 8;
        idx = 3'd0;
        for (int unsigned k = 1; k < 8; k++) begin
            if (x >= k * w) begin
                idx = idx + 3'd1;
            end
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi4_video_stream_checker_if.sv
`default_nettype none
// ============================================================================
//  Module      : axi4_stream_if
//  Description : AXI4-Stream video bus, 32-bit tdata with tuser (start of
//                frame) and tlast (end of line).
//                master : drives tvalid/tdata/tuser/tlast, receives tready
//                slave  : receives tvalid/tdata/tuser/tlast, drives tready
//  Revision    : 1.0  initial release
// ============================================================================
interface axi4_stream_if;

    logic        tvalid;
    logic        tready;
    logic [31:0] tdata;
    logic        tuser;
    logic        tlast;

    modport master (
        output tvalid,
        output tdata,
        output tuser,
        output tlast,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        input  tuser,
        input  tlast,
        output tready
    );

endinterface
`default_nettype wire

// File: rtl/axi4_video_stream_checker.sv
`default_nettype none
// ============================================================================
//  Module      : axi4_video_stream_checker
//  Description : AXI4-Stream video sink that checks colour-bar frames.
//                Verifies tuser (first pixel of frame) and tlast (last pixel
//                of each line) placement, optionally compares pixel data
//                against the 8-bar pattern, and reports sticky error flags,
//                error/frame counters and measured line length/frame height.
//  Ports       : clk_i           pixel clock
//                rst_i           asynchronous reset, active low
//                video_i         AXI4-Stream video input (slave, drives tready)
//                ready_en_i      enables tready (registered)
//                clear_i         synchronous clear of flags and counters
//                err_sof_o       sticky: tuser missing or mid-frame
//                err_eol_o       sticky: tlast early or missing
//                err_data_o      sticky: pixel mismatch
//                err_data_cnt_o  saturating mismatched-pixel count
//                frame_cnt_o     wrapping count of complete frames
//                frame_done_o    one-cycle pulse per complete frame
//                line_len_o      pixel count of the last terminated line
//                frame_lines_o   lines in the last completed/aborted frame
//  Revision    : 1.0  initial release
// ============================================================================
module axi4_video_stream_checker
    import axi4_video_pkg::*;
#(
    parameter int unsigned X_ACTIVE   = 1920,
    parameter int unsigned Y_ACTIVE   = 1080,
    parameter bit          CHECK_DATA = 1'b1
) (
    input  wire logic                          clk_i,
    input  wire logic                          rst_i,
    axi4_stream_if.slave                       video_i,
    input  wire logic                          ready_en_i,
    input  wire logic                          clear_i,
    output logic                               err_sof_o,
    output logic                               err_eol_o,
    output logic                               err_data_o,
    output logic [15:0]                        err_data_cnt_o,
    output logic [15:0]                        frame_cnt_o,
    output logic                               frame_done_o,
    output logic [$clog2(X_ACTIVE+1)-1:0]      line_len_o,
    output logic [$clog2(Y_ACTIVE+1)-1:0]      frame_lines_o
);

    localparam int XW = $clog2(X_ACTIVE + 1);
    localparam int YW = $clog2(Y_ACTIVE + 1);

    localparam logic [XW-1:0] c_x_last = XW'(X_ACTIVE - 1);
    localparam logic [XW-1:0] c_x_full = XW'(X_ACTIVE);
    localparam logic [YW-1:0] c_y_last = YW'(Y_ACTIVE - 1);
    localparam logic [YW-1:0] c_y_full = YW'(Y_ACTIVE);

    // ------------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------------
    state_t          r_state;
    logic [XW-1:0]   r_x;
    logic [YW-1:0]   r_y;
    logic            r_tready;
    logic            r_err_sof;
    logic            r_err_eol;
    logic            r_err_data;
    logic [15:0]     r_err_data_cnt;
    logic [15:0]     r_frame_cnt;
    logic            r_frame_done;
    logic [XW-1:0]   r_line_len;
    logic [YW-1:0]   r_frame_lines;

    // ------------------------------------------------------------------------
    // Next-state / event wires
    // ------------------------------------------------------------------------
    state_t          w_state_nxt;
    logic [XW-1:0]   w_x_nxt;
    logic [YW-1:0]   w_y_nxt;
    logic [XW-1:0]   w_line_len_nxt;
    logic [YW-1:0]   w_frame_lines_nxt;
    logic            w_frame_done_nxt;
    logic            w_set_sof;
    logic            w_set_eol;
    logic            w_set_data;
    logic            w_frame_inc;

    logic            w_beat;
    logic            w_pix;
    logic [XW-1:0]   w_px;
    logic [YW-1:0]   w_py;
    logic            w_last_px;
    logic [15:0]     w_err_cnt_base;
    logic [15:0]     w_frame_cnt_base;

    assign w_beat = video_i.tvalid & r_tready;

    // A beat becomes a frame pixel when it is inside a frame, or when it
    // carries tuser (which (re)starts a frame in any state).
    assign w_pix = w_beat & (video_i.tuser | (r_state == ACTIVE));

    // A tuser beat is always pixel (0,0), so the same line-end rules apply
    // to it as to any other pixel.
    assign w_px      = video_i.tuser ? '0 : r_x;
    assign w_py      = video_i.tuser ? '0 : r_y;
    assign w_last_px = (w_px == c_x_last);

    // ------------------------------------------------------------------------
    // Pixel data check
    // ------------------------------------------------------------------------
    if (CHECK_DATA) begin : g_data_chk
        logic [31:0] w_exp_pixel;
        assign w_exp_pixel = BAR_COLOURS[bar_idx(32'(w_px), X_ACTIVE)];
        // Bits [31:30] carry no colour information and are masked out.
        assign w_set_data  = w_pix &
                             ((video_i.tdata & 32'h3FFF_FFFF) !=
                              (w_exp_pixel   & 32'h3FFF_FFFF));
    end else begin : g_no_data_chk
        assign w_set_data = 1'b0;
    end

    // ------------------------------------------------------------------------
    // FSM: next state, position counters and measurement outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt       = r_state;
        w_x_nxt           = r_x;
        w_y_nxt           = r_y;
        w_line_len_nxt    = r_line_len;
        w_frame_lines_nxt = r_frame_lines;
        w_frame_done_nxt  = 1'b0;
        w_set_sof         = 1'b0;
        w_set_eol         = 1'b0;
        w_frame_inc       = 1'b0;

        if (w_beat) begin
            case (r_state)
                ACTIVE: begin
                    if (video_i.tuser) begin
                        // Unexpected start of frame: report the height of
                        // the frame being abandoned, then restart here.
                        w_set_sof         = 1'b1;
                        w_frame_lines_nxt = r_y;
                    end
                end
                EXPECT_SOF: begin
                    if (!video_i.tuser) begin
                        w_set_sof   = 1'b1;
                        w_state_nxt = WAIT_SOF;
                    end
                end
                default: begin
                    // WAIT_SOF: beats without tuser are dropped silently.
                end
            endcase
        end

        if (w_pix) begin
            w_state_nxt = ACTIVE;
            if (video_i.tlast && w_last_px) begin
                // Well-formed end of line
                w_line_len_nxt = c_x_full;
                w_x_nxt        = '0;
                if (w_py == c_y_last) begin
                    w_y_nxt           = '0;
                    w_frame_inc       = 1'b1;
                    w_frame_done_nxt  = 1'b1;
                    w_frame_lines_nxt = c_y_full;
                    w_state_nxt       = EXPECT_SOF;
                end else begin
                    w_y_nxt = w_py + YW'(1);
                end
            end else if (video_i.tlast) begin
                // Early tlast
                w_set_eol      = 1'b1;
                w_line_len_nxt = w_px + XW'(1);
                w_x_nxt        = '0;
                w_y_nxt        = '0;
                w_state_nxt    = WAIT_SOF;
            end else if (w_last_px) begin
                // tlast missing on the last pixel of the line
                w_set_eol      = 1'b1;
                w_line_len_nxt = c_x_full;
                w_x_nxt        = '0;
                w_y_nxt        = '0;
                w_state_nxt    = WAIT_SOF;
            end else begin
                w_x_nxt = w_px + XW'(1);
                w_y_nxt = w_py;
            end
        end
    end

    // Counters restart from zero on clear; an event in the same cycle then
    // increments from that zero base.
    assign w_err_cnt_base   = clear_i ? 16'd0 : r_err_data_cnt;
    assign w_frame_cnt_base = clear_i ? 16'd0 : r_frame_cnt;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state        <= WAIT_SOF;
            r_x            <= '0;
            r_y            <= '0;
            r_tready       <= 1'b0;
            r_err_sof      <= 1'b0;
            r_err_eol      <= 1'b0;
            r_err_data     <= 1'b0;
            r_err_data_cnt <= 16'd0;
            r_frame_cnt    <= 16'd0;
            r_frame_done   <= 1'b0;
            r_line_len     <= '0;
            r_frame_lines  <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_x           <= w_x_nxt;
            r_y           <= w_y_nxt;
            r_tready      <= ready_en_i;
            r_frame_done  <= w_frame_done_nxt;
            r_line_len    <= w_line_len_nxt;
            r_frame_lines <= w_frame_lines_nxt;

            r_err_sof  <= w_set_sof  | (r_err_sof  & ~clear_i);
            r_err_eol  <= w_set_eol  | (r_err_eol  & ~clear_i);
            r_err_data <= w_set_data | (r_err_data & ~clear_i);

            if (w_set_data && (w_err_cnt_base != 16'hFFFF)) begin
                r_err_data_cnt <= w_err_cnt_base + 16'd1;
            end else begin
                r_err_data_cnt <= w_err_cnt_base;
            end

            // Wraps 0xFFFF -> 0
            r_frame_cnt <= w_frame_inc ? (w_frame_cnt_base + 16'd1)
                                       : w_frame_cnt_base;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign video_i.tready = r_tready;
    assign err_sof_o      = r_err_sof;
    assign err_eol_o      = r_err_eol;
    assign err_data_o     = r_err_data;
    assign err_data_cnt_o = r_err_data_cnt;
    assign frame_cnt_o    = r_frame_cnt;
    assign frame_done_o   = r_frame_done;
    assign line_len_o     = r_line_len;
    assign frame_lines_o  = r_frame_lines;

endmodule
`default_nettype wire

// File: tb/tb_axi4_video_stream_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi4_video_stream_checker
//  Description : Self-checking bench for axi4_video_stream_checker with a
//                16x4 frame. Expected frame counts are queued as complete
//                frames are driven and popped on each frame_done_o pulse;
//                flags and measurements are checked directly after the
//                relevant beats.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_axi4_video_stream_checker;

    localparam int X = 16;
    localparam int Y = 4;
    localparam int NPIX = X * Y;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ready_en = 1'b0;
    logic        clear = 1'b0;
    logic        err_sof, err_eol, err_data, frame_done;
    logic [15:0] err_data_cnt, frame_cnt;
    logic [4:0]  line_len;
    logic [2:0]  frame_lines;

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_done   = 0;
    logic [15:0] exp_fc   = 16'd0;
    logic [15:0] sb_q [$];
    bit          bp_en    = 1'b0;

    axi4_stream_if vif ();

    axi4_video_stream_checker #(
        .X_ACTIVE   (X),
        .Y_ACTIVE   (Y),
        .CHECK_DATA (1'b1)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .video_i        (vif.slave),
        .ready_en_i     (ready_en),
        .clear_i        (clear),
        .err_sof_o      (err_sof),
        .err_eol_o      (err_eol),
        .err_data_o     (err_data),
        .err_data_cnt_o (err_data_cnt),
        .frame_cnt_o    (frame_cnt),
        .frame_done_o   (frame_done),
        .line_len_o     (line_len),
        .frame_lines_o  (frame_lines)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Colour bars are 2 pixels wide for a 16-pixel line.
    function automatic logic [31:0] exp_px(input int x);
        logic [31:0] tbl [8];
        tbl = '{32'h0000_0000, 32'h0000_03FF, 32'h000F_FC00, 32'h000F_FFFF,
                32'h3FF0_0000, 32'h3FF0_03FF, 32'h3FFF_FC00, 32'h3FFF_FFFF};
        return tbl[x / 2];
    endfunction

    // Scoreboard: each frame_done_o pulse pops the expected frame count.
    always @(negedge clk) begin
        if (rst && frame_done) begin
            n_done++;
            if (sb_q.size() == 0) begin
                check_val("done_unexpected", 32'd1, 32'd0);
            end else begin
                check_val("frame_cnt_sb", {16'd0, frame_cnt}, {16'd0, sb_q.pop_front()});
            end
        end
    end

    // Random backpressure
    always @(negedge clk) begin
        if (bp_en) ready_en = 1'($urandom_range(0, 1));
    end

    // Drive one beat at a negedge and hold it until it is accepted; returns
    // just after the accepting posedge.
    task automatic send_beat(input logic [31:0] d, input bit u, input bit l);
        int n;
        @(negedge clk);
        vif.tvalid = 1'b1;
        vif.tdata  = d;
        vif.tuser  = u;
        vif.tlast  = l;
        n = 0;
        while (!vif.tready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) check_val("tready_timeout", 32'd0, 32'd1);
        @(posedge clk);
    endtask

    // Drop tvalid at the next negedge; outputs for the last beat are visible.
    task automatic settle();
        @(negedge clk);
        vif.tvalid = 1'b0;
        vif.tuser  = 1'b0;
        vif.tlast  = 1'b0;
    endtask

    // Pixels p0..p1 of a well-formed frame; 'good' queues the frame count
    // when the final pixel is driven.
    task automatic send_span(input int p0, input int p1, input bit good);
        for (int p = p0; p <= p1; p++) begin
            if (good && p == NPIX - 1) begin
                exp_fc = exp_fc + 16'd1;
                sb_q.push_back(exp_fc);
            end
            send_beat(exp_px(p % X), p == 0, (p % X) == X - 1);
        end
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        exp_fc = 16'd0;
    endtask

    task automatic check_flags(input string tag, input logic s, input logic e,
                               input logic d);
        check_val({tag, "_err_sof"},  {31'd0, err_sof},  {31'd0, s});
        check_val({tag, "_err_eol"},  {31'd0, err_eol},  {31'd0, e});
        check_val({tag, "_err_data"}, {31'd0, err_data}, {31'd0, d});
    endtask

    int done0;

    initial begin
        vif.tvalid = 1'b0;
        vif.tdata  = 32'd0;
        vif.tuser  = 1'b0;
        vif.tlast  = 1'b0;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        check_val("rst_tready", {31'd0, vif.tready}, 32'd0);
        check_flags("rst", 1'b0, 1'b0, 1'b0);
        check_val("rst_err_cnt", {16'd0, err_data_cnt}, 32'd0);
        check_val("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
        check_val("rst_done", {31'd0, frame_done}, 32'd0);
        check_val("rst_line_len", {27'd0, line_len}, 32'd0);
        check_val("rst_frame_lines", {29'd0, frame_lines}, 32'd0);
        rst = 1'b1;
        ready_en = 1'b1;
        repeat (2) @(negedge clk);

        // ---------------- clean run ----------------
        done0 = n_done;
        for (int f = 0; f < 3; f++) send_span(0, NPIX - 1, 1'b1);
        settle();
        repeat (2) @(negedge clk);
        check_val("clean_frame_cnt", {16'd0, frame_cnt}, 32'd3);
        check_val("clean_done_pulses", n_done - done0, 32'd3);
        check_flags("clean", 1'b0, 1'b0, 1'b0);
        check_val("clean_line_len", {27'd0, line_len}, 32'd16);
        check_val("clean_frame_lines", {29'd0, frame_lines}, 32'd4);

        // ---------------- early tlast ----------------
        send_span(0, X + 8, 1'b0);
        send_beat(exp_px(9), 1'b0, 1'b1);
        settle();
        check_val("early_err_eol", {31'd0, err_eol}, 32'd1);
        check_val("early_line_len", {27'd0, line_len}, 32'd10);
        for (int i = 10; i < 13; i++) send_beat(exp_px(i), 1'b0, 1'b0);
        settle();
        check_val("early_discard_sof", {31'd0, err_sof}, 32'd0);
        send_span(0, NPIX - 1, 1'b1);
        settle();
        repeat (2) @(negedge clk);
        check_val("early_frame_cnt", {16'd0, frame_cnt}, 32'd4);
        check_flags("early_after", 1'b0, 1'b1, 1'b0);
        do_clear();

        // ---------------- data corruption ----------------
        send_span(0, 2 * X + 3, 1'b1);
        send_beat(32'h0000_0000, 1'b0, 1'b0);
        settle();
        check_val("data_err", {31'd0, err_data}, 32'd1);
        check_val("data_err_cnt", {16'd0, err_data_cnt}, 32'd1);
        send_span(2 * X + 5, NPIX - 1, 1'b1);
        settle();
        repeat (2) @(negedge clk);
        check_flags("data_after", 1'b0, 1'b0, 1'b1);
        do_clear();
        check_flags("clear", 1'b0, 1'b0, 1'b0);
        check_val("clear_err_cnt", {16'd0, err_data_cnt}, 32'd0);
        check_val("clear_frame_cnt", {16'd0, frame_cnt}, 32'd0);

        // ---------------- SOF: tuser mid-frame ----------------
        send_span(0, 2 * X + 4, 1'b0);
        send_beat(exp_px(0), 1'b1, 1'b0);
        settle();
        check_val("midsof_err_sof", {31'd0, err_sof}, 32'd1);
        check_val("midsof_frame_lines", {29'd0, frame_lines}, 32'd2);
        send_span(1, NPIX - 1, 1'b1);
        settle();
        repeat (2) @(negedge clk);
        check_val("midsof_restart_cnt", {16'd0, frame_cnt}, 32'd1);
        check_val("midsof_eol_clean", {31'd0, err_eol}, 32'd0);
        do_clear();

        // ---------------- SOF: missing after complete frame ----------------
        send_beat(exp_px(0), 1'b0, 1'b0);
        settle();
        check_val("nosof_err_sof", {31'd0, err_sof}, 32'd1);
        send_span(1, NPIX - 1, 1'b0);
        settle();
        repeat (2) @(negedge clk);
        check_val("nosof_frame_cnt", {16'd0, frame_cnt}, 32'd0);
        check_val("nosof_eol", {31'd0, err_eol}, 32'd0);
        do_clear();

        // ---------------- backpressure ----------------
        // Resync on a frame first; its count is then cleared.
        send_span(0, NPIX - 1, 1'b1);
        settle();
        repeat (2) @(negedge clk);
        do_clear();
        done0 = n_done;
        bp_en = 1'b1;
        for (int f = 0; f < 3; f++) send_span(0, NPIX - 1, 1'b1);
        settle();
        bp_en = 1'b0;
        ready_en = 1'b1;
        repeat (3) @(negedge clk);
        check_val("bp_frame_cnt", {16'd0, frame_cnt}, 32'd3);
        check_val("bp_done_pulses", n_done - done0, 32'd3);
        check_flags("bp", 1'b0, 1'b0, 1'b0);
        check_val("bp_line_len", {27'd0, line_len}, 32'd16);
        check_val("bp_frame_lines", {29'd0, frame_lines}, 32'd4);

        // ---------------- reset mid-frame ----------------
        send_span(0, 2 * X + 6, 1'b0);
        settle();
        rst = 1'b0;
        #1;
        check_val("midrst_tready", {31'd0, vif.tready}, 32'd0);
        check_val("midrst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
        check_val("midrst_line_len", {27'd0, line_len}, 32'd0);
        check_flags("midrst", 1'b0, 1'b0, 1'b0);
        exp_fc = 16'd0;
        @(negedge clk);
        rst = 1'b1;
        send_span(0, NPIX - 1, 1'b1);
        settle();
        repeat (2) @(negedge clk);
        check_val("postrst_frame_cnt", {16'd0, frame_cnt}, 32'd1);
        check_flags("postrst", 1'b0, 1'b0, 1'b0);
        check_val("postrst_err_cnt", {16'd0, err_data_cnt}, 32'd0);

        check_val("sb_queue_empty", sb_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Absolute time bound
    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
